store_buffer: RTL
=================

Name: store_buffer

Overview:
Write-side counterpart of the MEM/WB load-extension path. Accepts SB/SH/SW (and FSW, treated as SW) requests from the MEM stage and aligns data into byte lanes with per-byte write enables. Holds stores in a small FIFO and drains them to the data-memory write port over a req/ack handshake. Stalls the pipeline when full, and stalls loads that hit a pending store word.

Parameters:
DEPTH, 2, number of buffered store entries (power of 2, >=2)
AW, 32, address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
st_valid_mem  in  1  store request valid in MEM stage
st_type_mem  in  2  01=SB, 10=SH, 11=SW/FSW, 00=none
st_addr_mem  in  AW  byte address
st_data_mem  in  32  unaligned store data, LSB-justified
ld_valid_mem  in  1  load in MEM stage
ld_addr_mem  in  AW  load byte address
st_stall  out  1  buffer full; upstream holds the store
ld_stall  out  1  load word matches a pending entry
dm_req  out  1  write request to data memory
dm_ack  in  1  data memory accepted head entry
dm_addr  out  AW  word-aligned write address ({addr[AW-1:2],2'b00})
dm_bwe  out  4  active-high byte write enables
dm_wdata  out  32  lane-aligned write data
misalign_err  out  1  one-cycle pulse on misaligned store
buf_count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (sync, rst high at posedge) clears the FIFO, count, pointers and misalign_err. After that edge all outputs are 0. Reset mid-drain drops pending stores, and dm_req is 0 from the next cycle.
- Alignment (off = addr[1:0]):
  - SB: bwe = 4'b0001<<off; wdata = {4{data[7:0]}}.
  - SH: bwe = 4'b0011<<off; wdata = {2{data[15:0]}}.
  - SW: bwe = 4'b1111; wdata = data.
- Misaligned stores are not enqueued; misalign_err is registered and pulses high the cycle after the store:
  - SH with off[0]=1
  - SW with off!=0
- st_type_mem=00 with st_valid_mem=1: ignored, no error.
- st_stall = (count==DEPTH), combinational from registered count. No enqueue is accepted while full, even if a dequeue happens the same cycle.
- Enqueue when st_valid_mem && legal && !full. Dequeue when dm_req && dm_ack. Simultaneous enqueue and dequeue (not full) keeps count unchanged.
- Latency: a store accepted at edge N is visible on dm_req/dm_addr/dm_bwe/dm_wdata from cycle N+1. There is no bypass from input to output.
- dm_req = (count!=0). While dm_req=1 and dm_ack=0, dm_addr/dm_bwe/dm_wdata hold stable. When empty, dm_addr/dm_bwe/dm_wdata are 0.
- ld_stall = ld_valid_mem && any valid entry with entry.addr[AW-1:2]==ld_addr_mem[AW-1:2]. Combinational over registered entries; an entry being dequeued this cycle still counts. There is no store-to-load forwarding.
- If st_valid_mem and ld_valid_mem are both high (protocol violation), the store is processed and ld_stall is still evaluated.
- Pointers wrap modulo DEPTH. count saturates at 0..DEPTH, with no overflow or underflow.

Decomposition:
- Shared package:
  - st_type_e enum (ST_NONE, ST_B, ST_H, ST_W)
  - st_entry_t struct (addr, bwe[3:0], wdata[31:0])
  - BWE_B/BWE_H/BWE_W constants
- Sub-module store_align: combinational type+offset -> bwe/wdata/misaligned. Reused by the testbench scoreboard.
- The FIFO, handshake and hazard compare stay in store_buffer.

Test Plan:
- SB addr 0x1003 data 0x000000AB, dm_ack=1 -> next cycle dm_req=1, dm_addr=0x1000, dm_bwe=1000, dm_wdata=0xABABABAB; empty the following cycle.
- SH addr 0x2002 data 0x1234 with dm_ack=0 for 3 cycles -> dm_bwe=1100, dm_wdata=0x12341234 held stable; buf_count=1 until ack.
- Three SW stores back-to-back with dm_ack=0 (DEPTH=2) -> st_stall=1 after 2nd; 3rd held; ack releases entries in order; 3rd enqueued when count<2.
- SW addr 0x3001 -> misalign_err=1 for exactly one cycle; buf_count stays 0; dm_req stays 0.
- Pending SW at 0x4000, load at 0x4002 -> ld_stall=1; load at 0x4004 -> ld_stall=0.
- rst asserted while 2 entries are pending and dm_req=1 -> next cycle dm_req=0, buf_count=0, st_stall=0.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and lane-enable constants for the store buffer and its
// alignment helper.
package store_buffer_pkg;

   // Entry address field is wide enough for any supported AW (< ADDR_MAX).
   localparam int ADDR_MAX = 64;

   typedef enum logic [1:0] {
      ST_NONE = 2'b00,
      ST_B    = 2'b01,
      ST_H    = 2'b10,
      ST_W    = 2'b11
   } st_type_e;

   localparam logic [3:0] BWE_B = 4'b0001;
   localparam logic [3:0] BWE_H = 4'b0011;
   localparam logic [3:0] BWE_W = 4'b1111;

   typedef struct packed {
      logic [ADDR_MAX-1:0] addr;
      logic [3:0]          bwe;
      logic [31:0]         wdata;
   } st_entry_t;

endpackage

// File: rtl/store_align.sv
// Combinational store alignment: replicates data across byte lanes and
// derives byte enables and misalignment from type and address offset.
module store_align
   import store_buffer_pkg::*;
(
   input  logic [1:0]  i_type,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_data,
   output logic [3:0]  o_bwe,
   output logic [31:0] o_wdata,
   output logic        o_misaligned,
   output logic        o_legal
);

   st_type_e w_type;

   assign w_type = st_type_e'(i_type);

   // Replicating data into every lane lets the enables alone select the target bytes.
   always_comb begin
      o_bwe        = '0;
      o_wdata      = '0;
      o_misaligned = 1'b0;
      case (w_type)
         ST_B: begin
            o_bwe   = BWE_B << i_off;
            o_wdata = {4{i_data[7:0]}};
         end
         ST_H: begin
            if (i_off[0]) begin
               o_misaligned = 1'b1;
            end else begin
               o_bwe   = BWE_H << i_off;
               o_wdata = {2{i_data[15:0]}};
            end
         end
         ST_W: begin
            if (i_off != 2'b00) begin
               o_misaligned = 1'b1;
            end else begin
               o_bwe   = BWE_W;
               o_wdata = i_data;
            end
         end
         default: begin
            o_bwe   = '0;
            o_wdata = '0;
         end
      endcase
   end

   assign o_legal = (w_type != ST_NONE) && !o_misaligned;

endmodule

// File: rtl/store_buffer.sv
// Store buffer: aligns MEM-stage stores into byte lanes, queues them in a
// small FIFO and drains them to data memory over a req/ack handshake.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int AW    = 32
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     st_valid_mem,
   input  logic [1:0]               st_type_mem,
   input  logic [AW-1:0]            st_addr_mem,
   input  logic [31:0]              st_data_mem,
   input  logic                     ld_valid_mem,
   input  logic [AW-1:0]            ld_addr_mem,
   output logic                     st_stall,
   output logic                     ld_stall,
   output logic                     dm_req,
   input  logic                     dm_ack,
   output logic [AW-1:0]            dm_addr,
   output logic [3:0]               dm_bwe,
   output logic [31:0]              dm_wdata,
   output logic                     misalign_err,
   output logic [$clog2(DEPTH):0]   buf_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   st_entry_t          r_mem [DEPTH];
   logic [DEPTH-1:0]   r_valid;
   logic [PW-1:0]      r_head;
   logic [PW-1:0]      r_tail;
   logic [CW-1:0]      r_count;
   logic               r_misalign;

   logic [3:0]         w_bwe;
   logic [31:0]        w_wdata;
   logic               w_misaligned;
   logic               w_legal;
   logic               w_full;
   logic               w_enq;
   logic               w_deq;
   logic [CW-1:0]      w_countNext;
   logic [DEPTH-1:0]   w_validNext;
   logic               w_ldHit;
   st_entry_t          w_newEntry;
   st_entry_t          w_head;
   logic               w_unused;

   store_align u_align (
      .i_type       (st_type_mem),
      .i_off        (st_addr_mem[1:0]),
      .i_data       (st_data_mem),
      .o_bwe        (w_bwe),
      .o_wdata      (w_wdata),
      .o_misaligned (w_misaligned),
      .o_legal      (w_legal)
   );

   assign w_full = (r_count == CW'(DEPTH));
   assign w_enq  = st_valid_mem && w_legal && !w_full;
   assign w_deq  = dm_req && dm_ack;
   assign w_head = r_mem[r_head];

   // Only the word address is kept; byte position is already encoded in bwe.
   always_comb begin
      w_newEntry               = '0;
      w_newEntry.addr[AW-1:2]  = st_addr_mem[AW-1:2];
      w_newEntry.bwe           = w_bwe;
      w_newEntry.wdata         = w_wdata;
   end

   always_comb begin
      w_countNext = r_count;
      case ({w_enq, w_deq})
         2'b10:   w_countNext = r_count + CW'(1);
         2'b01:   w_countNext = r_count - CW'(1);
         default: w_countNext = r_count;
      endcase
   end

   always_comb begin
      w_validNext = r_valid;
      if (w_deq) begin
         w_validNext[r_head] = 1'b0;
      end
      if (w_enq) begin
         w_validNext[r_tail] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_valid    <= '0;
         r_misalign <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         r_misalign <= st_valid_mem && w_misaligned;
         r_count    <= w_countNext;
         r_valid    <= w_validNext;
         if (w_enq) begin
            r_mem[r_tail] <= w_newEntry;
            r_tail        <= r_tail + PW'(1);
         end
         if (w_deq) begin
            r_head <= r_head + PW'(1);
         end
      end
   end

   // An entry leaving this cycle still blocks the load: memory is not yet updated.
   always_comb begin
      w_ldHit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i] && (r_mem[i].addr[AW-1:2] == ld_addr_mem[AW-1:2])) begin
            w_ldHit = 1'b1;
         end
      end
   end

   assign ld_stall     = ld_valid_mem && w_ldHit;
   assign st_stall     = w_full;
   assign dm_req       = (r_count != '0);
   assign dm_addr      = dm_req ? {w_head.addr[AW-1:2], 2'b00} : '0;
   assign dm_bwe       = dm_req ? w_head.bwe : '0;
   assign dm_wdata     = dm_req ? w_head.wdata : '0;
   assign misalign_err = r_misalign;
   assign buf_count    = r_count;

   assign w_unused = ^{w_head.addr[ADDR_MAX-1:AW], w_head.addr[1:0], ld_addr_mem[1:0]};

endmodule
